// File: rtl/sevseg_pkg.sv
// Shared definitions for the 4-digit multiplexed seven-segment scan logic:
// slot FSM encoding, active-low digit enable codes, BCD field offsets and
// small decode helpers used by the scan controller.
package sevseg_pkg;

    typedef enum logic [1:0] {
        S_GUARD = 2'd0,
        S_ON    = 2'd1,
        S_OFF   = 2'd2
    } scan_state_t;

    localparam logic [3:0] DIGIT_OFF = 4'b1111;

    localparam int unsigned UNITS_LSB     = 0;
    localparam int unsigned TENS_LSB      = 4;
    localparam int unsigned HUNDREDS_LSB  = 8;
    localparam int unsigned THOUSANDS_LSB = 12;

    // Active-low one-hot enable for the digit at slot index idx.
    function automatic logic [3:0] digit_enable(input logic [1:0] idx);
        logic [3:0] code;
        case (idx)
            2'd0:    code = 4'b1110;
            2'd1:    code = 4'b1101;
            2'd2:    code = 4'b1011;
            2'd3:    code = 4'b0111;
            default: code = DIGIT_OFF;
        endcase
        return code;
    endfunction

    // BCD nibble of value belonging to slot index idx.
    function automatic logic [3:0] bcd_field(input logic [15:0] value, input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = value[UNITS_LSB     +: 4];
            2'd1:    nib = value[TENS_LSB      +: 4];
            2'd2:    nib = value[HUNDREDS_LSB  +: 4];
            2'd3:    nib = value[THOUSANDS_LSB +: 4];
            default: nib = 4'd0;
        endcase
        return nib;
    endfunction

    // Per-slot blank mask for leading-zero suppression; units is never blanked.
    function automatic logic [3:0] lz_blank_mask(input logic [15:0] value, input logic enable);
        logic [3:0] mask;
        mask[3] = enable && (value[THOUSANDS_LSB +: 4] == 4'd0);
        mask[2] = mask[3] && (value[HUNDREDS_LSB +: 4] == 4'd0);
        mask[1] = mask[2] && (value[TENS_LSB +: 4] == 4'd0);
        mask[0] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/sevseg_slot_timer.sv
// Slot timebase for the scan controller. tick_r/slot_idx_r describe the slot
// position of the cycle the controller's output registers will present after
// the next clock edge, so the strobes are used to load those registers.
module sevseg_slot_timer #(
    parameter int unsigned TICKS_PER_DIGIT = 50000,
    parameter int unsigned TICK_W          = $clog2(TICKS_PER_DIGIT)
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic [TICK_W-1:0] tick_r,
    output logic [1:0]        slot_idx_r,
    output logic              slot_start_s,
    output logic              frame_start_s
);

    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_DIGIT - 1);

    // Advance the tick within the slot and step the 2-bit slot index at slot end.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick_r     <= {TICK_W{1'b0}};
            slot_idx_r <= 2'd0;
        end else if (tick_r == LAST_TICK) begin
            tick_r     <= {TICK_W{1'b0}};
            slot_idx_r <= slot_idx_r + 2'd1;
        end else begin
            tick_r     <= tick_r + TICK_W'(1);
            slot_idx_r <= slot_idx_r;
        end
    end

    assign slot_start_s  = (tick_r == {TICK_W{1'b0}});
    assign frame_start_s = slot_start_s && (slot_idx_r == 2'd0);

endmodule

// File: rtl/sevseg_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller: time-slices digits
// with an anti-ghosting guard, applies PWM brightness within each slot,
// blanks leading zeros and double-buffers new values to frame boundaries.
module sevseg_scan_controller
    import sevseg_pkg::*;
#(
    parameter int unsigned TICKS_PER_DIGIT = 50000,
    parameter int unsigned GUARD_TICKS     = 500
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] VALUE,
    input  logic        LOAD,
    input  logic [3:0]  BRIGHTNESS,
    input  logic        BLANK_LZ,
    output logic [3:0]  DIGIT_DATA,
    output logic [3:0]  DIGIT,
    output logic        PENDING,
    output logic        FRAME_START
);

    localparam int unsigned TICK_W = $clog2(TICKS_PER_DIGIT);
    localparam int unsigned ON_W   = TICK_W + 1;
    localparam int unsigned CMP_W  = ON_W + 1;
    localparam int unsigned STEP   = TICKS_PER_DIGIT / 16;

    logic [TICK_W-1:0] tick_r;
    logic [1:0]        slot_idx_r;
    logic              slot_start_s;
    logic              frame_start_s;

    scan_state_t       state_r;
    logic [15:0]       shadow_r;
    logic [15:0]       display_r;
    logic              pending_r;
    logic [3:0]        blank_r;
    logic [ON_W-1:0]   on_ticks_r;
    logic [3:0]        digit_data_r;
    logic [3:0]        digit_r;
    logic              frame_start_r;

    logic [15:0]       display_next_s;
    logic [3:0]        blank_next_s;
    logic [3:0]        blank_cur_s;
    logic [ON_W-1:0]   on_cnt_s;
    logic [CMP_W-1:0]  tick_ext_s;
    logic [CMP_W-1:0]  win_end_s;
    logic              guard_s;
    logic              win_s;

    // Full brightness holds the digit on to the end of the slot.
    function automatic logic [ON_W-1:0] bright_ticks(input logic [3:0] level);
        logic [ON_W-1:0] n;
        if (level == 4'd15) begin
            n = ON_W'(TICKS_PER_DIGIT);
        end else begin
            n = ON_W'(level) * ON_W'(STEP);
        end
        return n;
    endfunction

    sevseg_slot_timer #(
        .TICKS_PER_DIGIT (TICKS_PER_DIGIT),
        .TICK_W          (TICK_W)
    ) u_slot_timer (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .tick_r        (tick_r),
        .slot_idx_r    (slot_idx_r),
        .slot_start_s  (slot_start_s),
        .frame_start_s (frame_start_s)
    );

    // Frame-boundary value selection, blank mask and on-window decode for the upcoming cycle.
    always_comb begin
        display_next_s = display_r;
        blank_next_s   = blank_r;
        blank_cur_s    = blank_r;
        on_cnt_s       = on_ticks_r;
        if (frame_start_s) begin
            if (LOAD) begin
                display_next_s = VALUE;
            end else if (pending_r) begin
                display_next_s = shadow_r;
            end else begin
                display_next_s = display_r;
            end
            blank_next_s = lz_blank_mask(display_next_s, BLANK_LZ);
            blank_cur_s  = blank_next_s;
        end else begin
            blank_cur_s = blank_r;
        end
        if (slot_start_s) begin
            on_cnt_s = bright_ticks(BRIGHTNESS);
        end else begin
            on_cnt_s = on_ticks_r;
        end
        tick_ext_s = CMP_W'(tick_r);
        win_end_s  = CMP_W'(GUARD_TICKS) + CMP_W'(on_cnt_s);
        guard_s    = (tick_ext_s < CMP_W'(GUARD_TICKS));
        win_s      = (tick_ext_s < win_end_s) && !blank_cur_s[slot_idx_r];
    end

    // Slot FSM: guard -> on window -> off, with the digit enable registered alongside the state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= S_GUARD;
            digit_r <= DIGIT_OFF;
        end else begin
            case (state_r)
                S_GUARD: begin
                    if (guard_s) begin
                        state_r <= S_GUARD;
                        digit_r <= DIGIT_OFF;
                    end else if (win_s) begin
                        state_r <= S_ON;
                        digit_r <= digit_enable(slot_idx_r);
                    end else begin
                        state_r <= S_OFF;
                        digit_r <= DIGIT_OFF;
                    end
                end
                S_ON: begin
                    if (guard_s) begin
                        state_r <= S_GUARD;
                        digit_r <= DIGIT_OFF;
                    end else if (win_s) begin
                        state_r <= S_ON;
                        digit_r <= digit_enable(slot_idx_r);
                    end else begin
                        state_r <= S_OFF;
                        digit_r <= DIGIT_OFF;
                    end
                end
                S_OFF: begin
                    if (guard_s) begin
                        state_r <= S_GUARD;
                        digit_r <= DIGIT_OFF;
                    end else if (slot_start_s && win_s) begin
                        state_r <= S_ON;
                        digit_r <= digit_enable(slot_idx_r);
                    end else begin
                        state_r <= S_OFF;
                        digit_r <= DIGIT_OFF;
                    end
                end
                default: begin
                    state_r <= S_GUARD;
                    digit_r <= DIGIT_OFF;
                end
            endcase
        end
    end

    // Shadow/display double buffer, slot latches and registered data outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_r      <= 16'd0;
            display_r     <= 16'd0;
            pending_r     <= 1'b0;
            blank_r       <= 4'd0;
            on_ticks_r    <= {ON_W{1'b0}};
            digit_data_r  <= 4'd0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= frame_start_s;
            if (slot_start_s) begin
                on_ticks_r   <= on_cnt_s;
                digit_data_r <= bcd_field(display_next_s, slot_idx_r);
            end else begin
                on_ticks_r   <= on_ticks_r;
                digit_data_r <= digit_data_r;
            end
            if (frame_start_s) begin
                display_r <= display_next_s;
                blank_r   <= blank_next_s;
                pending_r <= 1'b0;
                shadow_r  <= LOAD ? VALUE : shadow_r;
            end else if (LOAD) begin
                display_r <= display_r;
                blank_r   <= blank_r;
                pending_r <= 1'b1;
                shadow_r  <= VALUE;
            end else begin
                display_r <= display_r;
                blank_r   <= blank_r;
                pending_r <= pending_r;
                shadow_r  <= shadow_r;
            end
        end
    end

    assign DIGIT_DATA  = digit_data_r;
    assign DIGIT       = digit_r;
    assign PENDING     = pending_r;
    assign FRAME_START = frame_start_r;

endmodule
